// File: rtl/timer_pkg.sv
// Shared types and helpers for the seconds countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  // Prescaler width for a given clock rate, never narrower than one bit.
  function automatic int presc_w(input int clk_hz);
    if (clk_hz < 2) return 1;
    return $clog2(clk_hz);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..CLK_HZ-1 prescaler producing 1 Hz and 2 Hz tick requests.
// Ticks are flagged as the count steps onto its terminal values, so a register
// downstream lines its strobe up with the count actually reaching that value.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic one_hz_tick,
  output logic two_hz_tick
);

  localparam int PW = presc_w(CLK_HZ);
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2 - 1);

  logic [PW-1:0] count_q;
  logic [PW-1:0] count_step;
  logic [PW-1:0] count_d;

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    count_step = (count_q == LAST) ? '0 : count_q + 1'b1;
    count_d    = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_step;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign one_hz_tick = enable && !clear && (count_step == LAST);
  assign two_hz_tick = enable && !clear && ((count_step == LAST) || (count_step == HALF));

endmodule

// File: rtl/param_countdown_timer.sv
// Seconds countdown timer with built-in prescaler, pause and restart.
// Optional build macro: AUTO_RELOAD_EN (reload the last started value at zero
// and keep running instead of stopping in DONE).
//
// state | meaning
// IDLE  | out of reset, nothing loaded, no strobes
// RUN   | prescaler advancing, remaining decrements on each 1 Hz tick
// PAUSE | prescaler, remaining and strobes frozen until pause drops
// DONE  | count reached zero, expired held until restart or reset
module param_countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] value,
  input  logic             start_timer,
  input  logic             pause,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             expired,
  output logic             expired_pulse,
  output logic             one_hz_enable,
  output logic             two_hz_enable
);

  timer_state_t state_q;
  timer_state_t state_d;

  logic             counting;
  logic             one_hz_tick;
  logic             two_hz_tick;
  logic             final_tick;
  logic             reload_ok;
  logic [CNT_W-1:0] reload_value;

  logic [CNT_W-1:0] remaining_d;
  logic             busy_d;
  logic             expired_d;
  logic             expired_pulse_d;
  logic             one_hz_d;
  logic             two_hz_d;

  // PAUSE with pause released counts too, so resume loses no cycle and the
  // expiry slips by exactly the number of cycles pause was held.
  assign counting   = ((state_q == RUN) || (state_q == PAUSE)) && !pause && !start_timer;
  assign final_tick = counting && one_hz_tick && (remaining <= CNT_W'(1));

`ifdef AUTO_RELOAD_EN
  logic [CNT_W-1:0] value_q;

  // Remember the last started value for reloading at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
    end else if (start_timer) begin
      value_q <= value;
    end
  end

  assign reload_ok    = (value_q != '0);
  assign reload_value = value_q;
`else
  assign reload_ok    = 1'b0;
  assign reload_value = '0;
`endif

  tick_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_timer),
    .enable     (counting),
    .one_hz_tick(one_hz_tick),
    .two_hz_tick(two_hz_tick)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start overrides everything; pause beats a coincident tick.
  always_comb begin
    state_d = state_q;
    if (start_timer) begin
      state_d = (value == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (final_tick) begin
            state_d = reload_ok ? RUN : DONE;
          end
        end
        PAUSE: begin
          if (!pause) begin
            state_d = final_tick ? (reload_ok ? RUN : DONE) : RUN;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    remaining_d     = remaining;
    expired_d       = expired;
    expired_pulse_d = 1'b0;
    one_hz_d        = 1'b0;
    two_hz_d        = 1'b0;
    busy_d          = (state_d == RUN) || (state_d == PAUSE);
    if (start_timer) begin
      remaining_d     = value;
      expired_d       = (value == '0);
      expired_pulse_d = (value == '0);
    end else if (counting) begin
      one_hz_d = one_hz_tick;
      two_hz_d = two_hz_tick;
      if (final_tick) begin
        expired_pulse_d = 1'b1;
        if (reload_ok) begin
          remaining_d = reload_value;
        end else begin
          remaining_d = '0;
          expired_d   = 1'b1;
        end
      end else if (one_hz_tick) begin
        remaining_d = remaining - 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining     <= '0;
      busy          <= 1'b0;
      expired       <= 1'b0;
      expired_pulse <= 1'b0;
      one_hz_enable <= 1'b0;
      two_hz_enable <= 1'b0;
    end else begin
      remaining     <= remaining_d;
      busy          <= busy_d;
      expired       <= expired_d;
      expired_pulse <= expired_pulse_d;
      one_hz_enable <= one_hz_d;
      two_hz_enable <= two_hz_d;
    end
  end

endmodule

// File: tb/tb_param_countdown_timer.sv
// Directed bench for param_countdown_timer at CLK_HZ=10, CNT_W=5.
// Cycle k counts register updates since the cycle in which start_timer was high.
module tb_param_countdown_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] value;
  logic       start_timer;
  logic       pause;
  logic [4:0] remaining;
  logic       busy;
  logic       expired;
  logic       expired_pulse;
  logic       one_hz_enable;
  logic       two_hz_enable;

  int n_checks = 0;
  int n_fails  = 0;

  param_countdown_timer #(
    .CLK_HZ(10),
    .CNT_W (5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .value        (value),
    .start_timer  (start_timer),
    .pause        (pause),
    .remaining    (remaining),
    .busy         (busy),
    .expired      (expired),
    .expired_pulse(expired_pulse),
    .one_hz_enable(one_hz_enable),
    .two_hz_enable(two_hz_enable)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_all(input string tag, input int rem, input bit bsy, input bit exp,
                            input bit pls, input bit one, input bit two);
    check({tag, " remaining"}, 32'(remaining), 32'(rem));
    check({tag, " busy"}, 32'(busy), 32'(bsy));
    check({tag, " expired"}, 32'(expired), 32'(exp));
    check({tag, " expired_pulse"}, 32'(expired_pulse), 32'(pls));
    check({tag, " one_hz"}, 32'(one_hz_enable), 32'(one));
    check({tag, " two_hz"}, 32'(two_hz_enable), 32'(two));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int rem;
    reset       = 1'b1;
    start_timer = 1'b0;
    pause       = 1'b0;
    value       = '0;
    repeat (3) step();
    expect_all("por", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    expect_all("idle", 0, 0, 0, 0, 0, 0);

    // Reset held three cycles in the middle of a run.
    value       = 5'd5;
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    repeat (11) step();
    check("pre-reset busy", 32'(busy), 32'd1);
    check("pre-reset remaining", 32'(remaining), 32'd4);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    expect_all("mid-run reset", 0, 0, 0, 0, 0, 0);
    repeat (12) step();
    expect_all("post-reset idle", 0, 0, 0, 0, 0, 0);

`ifndef AUTO_RELOAD_EN
    // value=3: strobes and countdown to expiry.
    value       = 5'd3;
    start_timer = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      start_timer = 1'b0;
      rem = (k < 10) ? 3 : (k < 20) ? 2 : (k < 30) ? 1 : 0;
      expect_all($sformatf("v3 k=%0d", k), rem, k < 30, k >= 30, k == 30,
                 (k % 10) == 0, (k % 5) == 0);
    end

    // value=2 with pause held for cycles 4..10.
    value       = 5'd2;
    start_timer = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      step();
      start_timer = 1'b0;
      pause       = (k >= 4) && (k <= 10);
      rem = (k < 17) ? 2 : (k < 27) ? 1 : 0;
      expect_all($sformatf("pause k=%0d", k), rem, k < 27, k >= 27, k == 27,
                 (k == 17) || (k == 27), (k == 12) || (k == 17) || (k == 22) || (k == 27));
    end
    pause = 1'b0;
`endif

    // value=0 expires immediately and never ticks.
    value       = 5'd0;
    start_timer = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      start_timer = 1'b0;
      expect_all($sformatf("v0 k=%0d", k), 0, 1'b0, 1'b1, k == 1, 1'b0, 1'b0);
    end

    // value=4, restarted with value=9 in cycle 15.
    value       = 5'd4;
    start_timer = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      start_timer = (k == 15);
      if (k == 15) value = 5'd9;
      rem = (k < 10) ? 4 : (k < 16) ? 3 : (k < 25) ? 9 : 8;
      expect_all($sformatf("restart k=%0d", k), rem, 1'b1, 1'b0, 1'b0,
                 (k == 10) || (k == 25), (k % 5) == 0);
    end

`ifdef AUTO_RELOAD_EN
    // value=2 with auto reload: pulses every 20 cycles, never expires.
    value       = 5'd2;
    start_timer = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      step();
      start_timer = 1'b0;
      rem = (k < 10) ? 2 : (k < 20) ? 1 : (k < 30) ? 2 : (k < 40) ? 1 : 2;
      expect_all($sformatf("auto k=%0d", k), rem, 1'b1, 1'b0, (k == 20) || (k == 40),
                 (k % 10) == 0, (k % 5) == 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
